ttl_74153_scheduler: RTL and testbench

Round-robin controller that shares a ttl_74153-style multiplexer among WIDTH_IN requesters, one requester per mux data input. It drives the mux Select and per-block Enable_bar so that exactly one requester's inputs reach Y at a time. Every switch is break-before-make: outputs are disabled while Select moves, then re-enabled after a settle interval. It sits beside the mux instance and is its only source of Select and Enable_bar.

---
 rtl/ttl_74153_scheduler_pkg.sv | 12 +
 rtl/ttl_74153_scheduler_rr_pick.sv | 36 +++
 rtl/ttl_74153_scheduler.sv | 147 ++++++++++++++
 tb/tb_ttl_74153_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_74153_scheduler_pkg.sv
// Shared definitions for the ttl_74153 scheduler and sibling chip sequencers.
// Holds the controller state encodings.
package ttl_74153_scheduler_pkg;

   // Common control-state encoding; other sequencers decode these same values.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      GRANT  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/ttl_74153_scheduler_rr_pick.sv
// Combinational circular priority picker: first set request bit at or after ptr.
// WIDTH_IN must be a power of two so index arithmetic wraps naturally.
module rr_pick
   import ttl_74153_scheduler_pkg::*;
#(
   parameter int WIDTH_IN = 4
) (
   input  logic [WIDTH_IN-1:0]         req,
   input  logic [$clog2(WIDTH_IN)-1:0] ptr,
   output logic [$clog2(WIDTH_IN)-1:0] winner,
   output logic                        valid
);

   localparam int SEL_W = $clog2(WIDTH_IN);

   logic [WIDTH_IN-1:0] rotated;
   logic [SEL_W-1:0]    offset;

   // rotated[k] is the request k positions after ptr (modulo WIDTH_IN).
   for (genvar gi = 0; gi < WIDTH_IN; gi++) begin : g_rot
      assign rotated[gi] = req[ptr + SEL_W'(gi)];
   end

   always_comb begin
      offset = '0;
      for (int i = WIDTH_IN - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            offset = SEL_W'(i);
         end
      end
   end

   assign winner = ptr + offset;
   assign valid  = |req;

endmodule

// File: rtl/ttl_74153_scheduler.sv
// Round-robin, break-before-make owner of a ttl_74153 mux's Select and Enable_bar.
// Outputs are disabled while Select moves and re-enabled after a settle interval.
module ttl_74153_scheduler
   import ttl_74153_scheduler_pkg::*;
#(
   parameter int BLOCKS        = 2,
   parameter int WIDTH_IN      = 4,
   parameter int SETTLE_CYCLES = 1,
   parameter int MAX_HOLD      = 8,
   parameter int DELAY_RISE    = 0,
   parameter int DELAY_FALL    = 0
) (
   input  logic                        Clk,
   input  logic                        Clear_bar,
   input  logic [WIDTH_IN-1:0]         Req,
   input  logic                        Done,
   input  logic [BLOCKS-1:0]           Block_mask,
   output logic [$clog2(WIDTH_IN)-1:0] Select,
   output logic [BLOCKS-1:0]           Enable_bar,
   output logic [WIDTH_IN-1:0]         Grant,
   output logic                        Busy
);

   localparam int SEL_W  = $clog2(WIDTH_IN);
   localparam int SC_W   = $clog2(SETTLE_CYCLES + 1);
   localparam int HOLD_W = $clog2(MAX_HOLD + 2);
   localparam logic [SC_W-1:0]     SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   HOLD_MAX    = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [WIDTH_IN-1:0] ONE         = WIDTH_IN'(1);

   if (SETTLE_CYCLES < 1 || WIDTH_IN < 2 || (WIDTH_IN & (WIDTH_IN - 1)) != 0 ||
       DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
      $error("ttl_74153_scheduler: illegal parameter combination");
   end

   ctrl_state_t         state_reg, state_next;
   logic [SEL_W-1:0]    select_reg, select_next;
   logic [BLOCKS-1:0]   enable_bar_reg, enable_bar_next;
   logic [WIDTH_IN-1:0] grant_reg, grant_next;
   logic                busy_reg, busy_next;
   logic [SEL_W-1:0]    ptr_reg, ptr_next;
   logic [HOLD_W-1:0]   hold_reg, hold_next;
   logic [SC_W-1:0]     settle_reg, settle_next;

   logic [SEL_W-1:0]    pick_idx;
   logic                pick_valid;
   logic [WIDTH_IN-1:0] owner_onehot;
   logic                owner_req;
   logic                timeout;
   logic                release_now;

   rr_pick #(.WIDTH_IN(WIDTH_IN)) u_pick (
      .req    (Req),
      .ptr    (ptr_reg),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   // Select always holds the current (or last) winner, so it doubles as the owner index.
   assign owner_onehot = ONE << select_reg;
   assign owner_req    = Req[select_reg];
   assign timeout      = (MAX_HOLD != 0) && (hold_reg == HOLD_LAST) && (|(Req & ~owner_onehot));
   assign release_now  = Done || !owner_req || timeout;

   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         state_reg      <= IDLE;
         select_reg     <= '0;
         enable_bar_reg <= '1;
         grant_reg      <= '0;
         busy_reg       <= 1'b0;
         ptr_reg        <= '0;
         hold_reg       <= '0;
         settle_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         select_reg     <= select_next;
         enable_bar_reg <= enable_bar_next;
         grant_reg      <= grant_next;
         busy_reg       <= busy_next;
         ptr_reg        <= ptr_next;
         hold_reg       <= hold_next;
         settle_reg     <= settle_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (pick_valid) state_next = SETTLE;
         SETTLE:  if (!owner_req) state_next = IDLE;
                  else if (settle_reg == '0) state_next = GRANT;
         GRANT:   if (release_now) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      select_next     = select_reg;
      enable_bar_next = '1;
      grant_next      = '0;
      busy_next       = busy_reg;
      ptr_next        = ptr_reg;
      hold_next       = hold_reg;
      settle_next     = settle_reg;
      unique case (state_reg)
         IDLE: begin
            busy_next = 1'b0;
            if (pick_valid) begin
               select_next = pick_idx;
               busy_next   = 1'b1;
               settle_next = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            // An abort leaves Ptr alone so the same requester keeps priority.
            if (!owner_req) begin
               busy_next = 1'b0;
            end else if (settle_reg == '0) begin
               enable_bar_next = ~Block_mask;
               grant_next      = owner_onehot;
               hold_next       = '0;
            end else begin
               settle_next = settle_reg - 1'b1;
            end
         end
         GRANT: begin
            if (release_now) begin
               busy_next = 1'b0;
               ptr_next  = select_reg + 1'b1;
            end else begin
               enable_bar_next = ~Block_mask;
               grant_next      = owner_onehot;
               if (hold_reg != HOLD_MAX) hold_next = hold_reg + 1'b1;
            end
         end
         default: busy_next = 1'b0;
      endcase
   end

   assign Select     = select_reg;
   assign Enable_bar = enable_bar_reg;
   assign Grant      = grant_reg;
   assign Busy       = busy_reg;

endmodule

// File: tb/tb_ttl_74153_scheduler.sv
// Scoreboard bench for ttl_74153_scheduler: stimulus queues expected grants,
// a negedge monitor pops and checks them as grants appear on the outputs.
module tb_ttl_74153_scheduler;

   logic       clk;
   logic       clear_bar;
   logic [3:0] req;
   logic       done_man;
   logic       done_auto;
   logic       auto_en;
   logic       done;
   logic [1:0] block_mask;
   logic [1:0] select;
   logic [1:0] enable_bar;
   logic [3:0] grant;
   logic       busy;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] sel;
      logic [1:0] en;
      int         at_cyc;
      int         len;
   } exp_t;

   exp_t exp_q[$];

   assign done = done_man | done_auto;

   ttl_74153_scheduler #(
      .BLOCKS(2), .WIDTH_IN(4), .SETTLE_CYCLES(1), .MAX_HOLD(8),
      .DELAY_RISE(0), .DELAY_FALL(0)
   ) dut (
      .Clk        (clk),
      .Clear_bar  (clear_bar),
      .Req        (req),
      .Done       (done),
      .Block_mask (block_mask),
      .Select     (select),
      .Enable_bar (enable_bar),
      .Grant      (grant),
      .Busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [3:0] g, input logic [1:0] s, input logic [1:0] e,
                           input int at, input int len);
      exp_t r;
      r.grant = g; r.sel = s; r.en = e; r.at_cyc = at; r.len = len;
      exp_q.push_back(r);
   endtask

   // Request one owner, check the settle cycle, hold the grant len cycles, then release.
   task automatic grant_once(input logic [3:0] r, input int owner, input logic [1:0] en_exp,
                             input int len);
      push_exp(4'(1 << owner), 2'(owner), en_exp, cyc + 2, len);
      req = r;
      step();
      check("settle_select", select, owner);
      check("settle_enable_bar", enable_bar, 2'b11);
      check("settle_grant", grant, 4'b0000);
      check("settle_busy", busy, 1'b1);
      step();
      repeat (len - 1) step();
      done_man = 1'b1;
      req      = 4'b0000;
      step();
      done_man = 1'b0;
      check("released_grant", grant, 4'b0000);
      check("released_enable_bar", enable_bar, 2'b11);
   endtask

   initial begin
      done_auto = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         done_auto = auto_en && (grant != 4'b0000);
      end
   end

   // Monitor: grant start/end detection, per-grant and per-cycle checks.
   initial begin
      logic [3:0] prev_grant = 4'b0000;
      logic [1:0] prev_sel   = 2'b00;
      int         gap        = 100;
      int         glen       = 0;
      bit         had_grant  = 1'b0;
      exp_t       cur;
      cur.len = -1;
      forever begin
         @(negedge clk);
         if (grant != 4'b0000 && prev_grant == 4'b0000) begin
            if (exp_q.size() == 0) begin
               check("unexpected_grant", grant, 4'b0000);
               cur.len = -1;
            end else begin
               cur = exp_q.pop_front();
               $display("[TB] grant %b sel %0d en_bar %b at cycle %0d", grant, select, enable_bar, cyc);
               check("grant_owner", grant, cur.grant);
               check("grant_select", select, cur.sel);
               check("grant_enable_bar", enable_bar, cur.en);
               check("grant_busy", busy, 1'b1);
               if (cur.at_cyc >= 0) check("grant_latency", cyc, cur.at_cyc);
               if (had_grant) check("gap_min_2", gap >= 2, 1'b1);
            end
            had_grant = 1'b1;
            glen = 1;
         end else if (grant != 4'b0000) begin
            check("grant_stable", grant, prev_grant);
            glen++;
         end
         if (grant == 4'b0000) begin
            if (prev_grant != 4'b0000) begin
               if (cur.len >= 0) check("grant_length", glen, cur.len);
               gap = 1;
            end else begin
               gap++;
            end
         end
         check("enable_while_select_stable",
               (enable_bar == 2'b11) || ((grant != 4'b0000) && (select == prev_sel)), 1'b1);
         prev_grant = grant;
         prev_sel   = select;
      end
   end

   initial begin
      bit got;
      clear_bar  = 1'b1;
      req        = 4'b0000;
      done_man   = 1'b0;
      auto_en    = 1'b0;
      block_mask = 2'b11;
      #1 clear_bar = 1'b0;
      #2;
      check("reset_select", select, 2'b00);
      check("reset_enable_bar", enable_bar, 2'b11);
      check("reset_grant", grant, 4'b0000);
      check("reset_busy", busy, 1'b0);
      step();
      step();
      clear_bar = 1'b1;

      // Single request to input C.
      grant_once(4'b0100, 2, 2'b00, 3);

      // Round robin from Ptr=0 with Done pulsed on every grant.
      step();
      clear_bar = 1'b0;
      step();
      clear_bar = 1'b1;
      push_exp(4'b0001, 2'd0, 2'b00, cyc + 2, 1);
      push_exp(4'b0010, 2'd1, 2'b00, -1, 1);
      push_exp(4'b0100, 2'd2, 2'b00, -1, 1);
      push_exp(4'b1000, 2'd3, 2'b00, -1, 1);
      push_exp(4'b0001, 2'd0, 2'b00, -1, 1);
      auto_en = 1'b1;
      req     = 4'b1111;
      got     = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (exp_q.size() == 0) begin got = 1'b1; break; end
      end
      check("rr_sequence_seen", got, 1'b1);
      req     = 4'b0000;
      auto_en = 1'b0;
      step();
      step();

      // Timeout: owners 1 and 0 each cut off after 8 cycles; sole owner holds.
      push_exp(4'b0010, 2'd1, 2'b00, cyc + 2, 8);
      push_exp(4'b0001, 2'd0, 2'b00, -1, 8);
      push_exp(4'b0010, 2'd1, 2'b00, -1, -1);
      req = 4'b0011;
      got = 1'b0;
      for (int k = 0; k < 80; k++) begin
         step();
         if (exp_q.size() == 0) begin got = 1'b1; break; end
      end
      check("timeout_sequence_seen", got, 1'b1);
      req = 4'b0010;
      repeat (20) step();
      check("sole_owner_holds", grant, 4'b0010);
      done_man = 1'b1;
      req      = 4'b0000;
      step();
      done_man = 1'b0;
      step();

      // Request withdrawn during SETTLE: no grant, Ptr stays at 2.
      req = 4'b0100;
      step();
      check("abort_busy_settle", busy, 1'b1);
      req = 4'b0000;
      step();
      check("abort_busy", busy, 1'b0);
      check("abort_grant", grant, 4'b0000);
      check("abort_enable_bar", enable_bar, 2'b11);
      step();
      grant_once(4'b1100, 2, 2'b00, 2);

      // Live Block_mask during GRANT.
      push_exp(4'b1000, 2'd3, 2'b10, cyc + 2, 4);
      block_mask = 2'b01;
      req        = 4'b1000;
      step();
      step();
      step();
      check("mask01_enable_bar", enable_bar, 2'b10);
      block_mask = 2'b11;
      step();
      check("mask11_enable_bar", enable_bar, 2'b00);
      step();
      done_man = 1'b1;
      req      = 4'b0000;
      step();
      done_man = 1'b0;

      // Empty mask: grant proceeds with every block disabled.
      block_mask = 2'b00;
      grant_once(4'b0001, 0, 2'b11, 2);
      block_mask = 2'b11;

      // Asynchronous clear mid-grant, then arbitration restarts from Ptr=0.
      push_exp(4'b0010, 2'd1, 2'b00, cyc + 2, -1);
      req = 4'b0010;
      step();
      step();
      step();
      clear_bar = 1'b0;
      #1;
      check("clear_enable_bar", enable_bar, 2'b11);
      check("clear_grant", grant, 4'b0000);
      check("clear_select", select, 2'b00);
      check("clear_busy", busy, 1'b0);
      req = 4'b1000;
      step();
      clear_bar = 1'b1;
      push_exp(4'b1000, 2'd3, 2'b00, cyc + 2, 2);
      step();
      check("post_clear_select", select, 2'd3);
      step();
      step();
      done_man = 1'b1;
      req      = 4'b0000;
      step();
      done_man = 1'b0;

      repeat (4) step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
